// File: rtl/input_p4_interface_pkg.sv
// Shared definitions for the VLAN-steered input interface: header field
// offsets, buffer sizing and the dispatcher state encoding.
package input_p4_interface_pkg;

  localparam logic [15:0] VLAN_TPID = 16'h8100;

  // Byte positions of the ethertype and VLAN ID inside the first data beat
  localparam int unsigned ETH_TYPE_HI_LSB = 96;
  localparam int unsigned ETH_TYPE_LO_LSB = 104;
  localparam int unsigned VID_HI_LSB      = 112;
  localparam int unsigned VID_LO_LSB      = 120;

  localparam int unsigned MAX_PKT_SIZE    = 2000;
  localparam int unsigned FIFO_DEPTH_BITS = $clog2(MAX_PKT_SIZE / 32);
  localparam int unsigned NUM_LANES       = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  function automatic logic [15:0] get_ethertype(input logic [127:0] hdr);
    return {hdr[ETH_TYPE_HI_LSB +: 8], hdr[ETH_TYPE_LO_LSB +: 8]};
  endfunction

  function automatic logic [11:0] get_vid(input logic [127:0] hdr);
    return {hdr[VID_HI_LSB +: 4], hdr[VID_LO_LSB +: 8]};
  endfunction

endpackage

// File: rtl/input_p4_interface_fifo.sv
// Show-ahead FIFO: the head entry is visible on dout whenever empty is low.
module fallthrough_small_fifo #(
  parameter int unsigned WIDTH          = 72,
  parameter int unsigned MAX_DEPTH_BITS = 3,
  parameter int unsigned NEARLY_FULL    = 2**MAX_DEPTH_BITS - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int unsigned DEPTH = 2**MAX_DEPTH_BITS;

  logic [WIDTH-1:0]        mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      do_wr;
  logic                      do_rd;

  assign empty       = (count == '0);
  assign nearly_full = (count >= (MAX_DEPTH_BITS+1)'(NEARLY_FULL));
  assign do_rd       = rd_en & ~empty;
  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands
  assign do_wr       = wr_en & ((count != (MAX_DEPTH_BITS+1)'(DEPTH)) | do_rd);
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_p4_interface.sv
// Buffers an AXI-Stream of packets and steers each one to the output lane
// named by its 802.1Q VLAN ID; untagged or out-of-range packets are discarded.
module input_p4_interface
  import input_p4_interface_pkg::*;
#(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = C_S_AXIS_DATA_WIDTH,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 304,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 304,
  parameter int unsigned NUM_QUEUES           = 5
) (
  input  logic                                 axis_aclk,
  input  logic                                 axis_reset,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [(C_S_AXIS_DATA_WIDTH/8)-1:0]   s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_0_tdata,
  output logic [(C_M_AXIS_DATA_WIDTH/8)-1:0]   m_axis_0_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_0_tuser,
  output logic                                 m_axis_0_tvalid,
  input  logic                                 m_axis_0_tready,
  output logic                                 m_axis_0_tlast,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_1_tdata,
  output logic [(C_M_AXIS_DATA_WIDTH/8)-1:0]   m_axis_1_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_1_tuser,
  output logic                                 m_axis_1_tvalid,
  input  logic                                 m_axis_1_tready,
  output logic                                 m_axis_1_tlast,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_2_tdata,
  output logic [(C_M_AXIS_DATA_WIDTH/8)-1:0]   m_axis_2_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_2_tuser,
  output logic                                 m_axis_2_tvalid,
  input  logic                                 m_axis_2_tready,
  output logic                                 m_axis_2_tlast,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_3_tdata,
  output logic [(C_M_AXIS_DATA_WIDTH/8)-1:0]   m_axis_3_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_3_tuser,
  output logic                                 m_axis_3_tvalid,
  input  logic                                 m_axis_3_tready,
  output logic                                 m_axis_3_tlast,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_4_tdata,
  output logic [(C_M_AXIS_DATA_WIDTH/8)-1:0]   m_axis_4_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_4_tuser,
  output logic                                 m_axis_4_tvalid,
  input  logic                                 m_axis_4_tready,
  output logic                                 m_axis_4_tlast,

  output logic                                 pkt_fwd,
  output logic                                 pkt_drop
);

  localparam int unsigned KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned FIFO_W = C_S_AXIS_DATA_WIDTH + C_S_AXIS_TUSER_WIDTH + KEEP_W + 1;

  logic [FIFO_W-1:0]               fifo_din;
  logic [FIFO_W-1:0]               fifo_dout;
  logic                            fifo_nearly_full;
  logic                            fifo_empty;
  logic                            fifo_wr;
  logic                            fifo_rd;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  head_tdata;
  logic [KEEP_W-1:0]               head_tkeep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] head_tuser;
  logic                            head_tlast;

  logic [15:0]                     ethertype;
  logic [11:0]                     vid;
  logic [2:0]                      dest;
  logic                            head_ok;

  state_t                          state;
  state_t                          state_next;
  logic [2:0]                      cur_lane;
  logic [2:0]                      lane_next;
  logic                            fwd_active;
  logic                            sel_ready;
  logic [NUM_LANES-1:0]            lane_ready;
  logic [NUM_LANES-1:0]            lane_valid;

  assign fifo_din      = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
  assign s_axis_tready = ~fifo_nearly_full;
  assign fifo_wr       = s_axis_tvalid & s_axis_tready;

  fallthrough_small_fifo #(
    .WIDTH          (FIFO_W),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk         (axis_aclk),
    .reset       (axis_reset),
    .din         (fifo_din),
    .wr_en       (fifo_wr),
    .rd_en       (fifo_rd),
    .dout        (fifo_dout),
    .nearly_full (fifo_nearly_full),
    .empty       (fifo_empty)
  );

  assign {head_tlast, head_tuser, head_tkeep, head_tdata} = fifo_dout;

  assign ethertype = get_ethertype(head_tdata[127:0]);
  assign vid       = get_vid(head_tdata[127:0]);
  assign dest      = vid[2:0];
  assign head_ok   = (ethertype == VLAN_TPID) && (vid < 12'(NUM_QUEUES));

  assign lane_ready = {m_axis_4_tready, m_axis_3_tready, m_axis_2_tready,
                       m_axis_1_tready, m_axis_0_tready};

  always_comb begin
    sel_ready  = 1'b0;
    lane_valid = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (cur_lane == 3'(i)) begin
        sel_ready     = lane_ready[i];
        lane_valid[i] = fwd_active;
      end
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state    <= IDLE;
      cur_lane <= '0;
    end else begin
      state    <= state_next;
      cur_lane <= lane_next;
    end
  end

  // The head beat is only inspected in IDLE; it is popped later by FWD/DROP
  always_comb begin
    state_next = state;
    lane_next  = cur_lane;
    pkt_fwd    = 1'b0;
    pkt_drop   = 1'b0;
    fifo_rd    = 1'b0;
    fwd_active = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          lane_next = dest;
          if (head_ok) begin
            pkt_fwd    = 1'b1;
            state_next = FWD;
          end else begin
            pkt_drop   = 1'b1;
            state_next = DROP;
          end
        end
      end
      FWD: begin
        fwd_active = ~fifo_empty;
        if (fwd_active && sel_ready) begin
          fifo_rd = 1'b1;
          if (head_tlast) state_next = IDLE;
        end
      end
      DROP: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          if (head_tlast) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_axis_0_tvalid = lane_valid[0];
  assign m_axis_1_tvalid = lane_valid[1];
  assign m_axis_2_tvalid = lane_valid[2];
  assign m_axis_3_tvalid = lane_valid[3];
  assign m_axis_4_tvalid = lane_valid[4];

  assign m_axis_0_tdata = head_tdata;
  assign m_axis_1_tdata = head_tdata;
  assign m_axis_2_tdata = head_tdata;
  assign m_axis_3_tdata = head_tdata;
  assign m_axis_4_tdata = head_tdata;

  assign m_axis_0_tkeep = head_tkeep;
  assign m_axis_1_tkeep = head_tkeep;
  assign m_axis_2_tkeep = head_tkeep;
  assign m_axis_3_tkeep = head_tkeep;
  assign m_axis_4_tkeep = head_tkeep;

  assign m_axis_0_tuser = head_tuser;
  assign m_axis_1_tuser = head_tuser;
  assign m_axis_2_tuser = head_tuser;
  assign m_axis_3_tuser = head_tuser;
  assign m_axis_4_tuser = head_tuser;

  assign m_axis_0_tlast = head_tlast;
  assign m_axis_1_tlast = head_tlast;
  assign m_axis_2_tlast = head_tlast;
  assign m_axis_3_tlast = head_tlast;
  assign m_axis_4_tlast = head_tlast;

endmodule
